// File: rtl/nw_job_scheduler.sv
// Round-robin front end sharing one Needleman-Wunsch grid among NREQ requesters.
// Latches a job onto the grid, pulses grid_reset, watches for valid, returns the score.
module nw_job_scheduler #(
  parameter int NREQ       = 4,
  parameter int LENGTH     = 10,
  parameter int CWIDTH     = 2,
  parameter int SWIDTH     = 16,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 1023,
  parameter int IDW        = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*LENGTH*CWIDTH-1:0]  req_s1,
  input  logic [NREQ*LENGTH*CWIDTH-1:0]  req_s2,
  output logic [LENGTH*CWIDTH-1:0]       grid_s1,
  output logic [LENGTH*CWIDTH-1:0]       grid_s2,
  output logic                           grid_reset,
  input  logic                           grid_valid,
  input  logic [SWIDTH-1:0]              grid_score,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [IDW-1:0]                 resp_id,
  output logic [SWIDTH-1:0]              resp_score,
  output logic                           resp_timeout,
  output logic                           busy
);

  localparam int SW   = LENGTH * CWIDTH;
  localparam int CNTW = $clog2(TIMEOUT + CLR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  ptr_next;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [CNTW-1:0] cnt;
  logic            hs;
  int              idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      grant[j] = found && (int'(win) == j);
    end
  end

  assign ptr_next  = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      grid_reset   <= 1'b1;
      grid_s1      <= '0;
      grid_s2      <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_score   <= '0;
      resp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          grid_reset <= 1'b0;
          if (hs) begin
            grid_s1    <= req_s1[int'(win)*SW +: SW];
            grid_s2    <= req_s2[int'(win)*SW +: SW];
            resp_id    <= win;
            ptr        <= ptr_next;
            cnt        <= '0;
            grid_reset <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == CNTW'(CLR_CYCLES - 1)) begin
            cnt        <= '0;
            grid_reset <= 1'b0;
            state      <= RUN;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        RUN: begin
          // first RUN cycle may still see the previous job's valid
          if (cnt != '0 && grid_valid) begin
            resp_score   <= grid_score;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else if (cnt == CNTW'(TIMEOUT - 1)) begin
            resp_score   <= '0;
            resp_timeout <= 1'b1;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nw_job_scheduler.sv
// Directed bench for nw_job_scheduler with a small behavioural grid model.
// Covers reset, single job, fairness, backpressure, timeout, stale valid, mid-job reset.
module tb_nw_job_scheduler;

  localparam int NREQ = 4;
  localparam int LENGTH = 10;
  localparam int CWIDTH = 2;
  localparam int SWIDTH = 16;
  localparam int CLR = 2;
  localparam int TMO = 31;
  localparam int IDW = 3;
  localparam int SW = LENGTH * CWIDTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*SW-1:0] req_s1;
  logic [NREQ*SW-1:0] req_s2;
  logic [SW-1:0] grid_s1;
  logic [SW-1:0] grid_s2;
  logic grid_reset;
  logic grid_valid;
  logic [SWIDTH-1:0] grid_score;
  logic resp_valid;
  logic resp_ready;
  logic [IDW-1:0] resp_id;
  logic [SWIDTH-1:0] resp_score;
  logic resp_timeout;
  logic busy;

  nw_job_scheduler #(
    .NREQ(NREQ), .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH),
    .CLR_CYCLES(CLR), .TIMEOUT(TMO), .IDW(IDW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s1(req_s1), .req_s2(req_s2),
    .grid_s1(grid_s1), .grid_s2(grid_s2),
    .grid_reset(grid_reset), .grid_valid(grid_valid),
    .grid_score(grid_score),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_score(resp_score),
    .resp_timeout(resp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // grid model: cycle count since grid_reset dropped
  int gcnt = 0;
  logic model_en;
  logic stale_force;
  int model_delay;
  logic [SWIDTH-1:0] model_score;

  always @(posedge clk) begin
    if (grid_reset) gcnt <= 0;
    else gcnt <= gcnt + 1;
  end

  assign grid_valid = stale_force | (model_en && gcnt >= model_delay);
  assign grid_score = model_score;

  int n_assert = 0;
  int n_fail = 0;
  logic [SW-1:0] s1v [NREQ];
  logic [SW-1:0] s2v [NREQ];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] enc(string s);
    logic [SW-1:0] r;
    byte c;
    r = '0;
    for (int i = 0; i < LENGTH; i++) begin
      c = s[i];
      r[2*i +: 2] = (c == "C") ? 2'd1 : (c == "G") ? 2'd2 :
                    (c == "T") ? 2'd3 : 2'd0;
    end
    return r;
  endfunction

  task automatic wait_grant(output int idx);
    int n;
    idx = -1;
    n = 0;
    #1;
    while (!(|(req_valid & req_ready)) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_assert++;
    assert (|(req_valid & req_ready)) else begin
      n_fail++;
      $error("FAIL grant_wait: observed no grant expected grant within %0d cycles", n);
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    assert (resp_valid) else begin
      n_fail++;
      $error("FAIL resp_wait: observed no resp_valid expected it within %0d cycles", n);
    end
  endtask

  int g;
  int n;

  initial begin
    req_valid = '0;
    resp_ready = 1'b1;
    model_en = 1'b1;
    stale_force = 1'b0;
    model_delay = 20;
    model_score = 16'd10;
    for (int k = 0; k < NREQ; k++) begin
      s1v[k] = enc("ACGTACGTAC") ^ (SW'(k) * 20'h11111);
      s2v[k] = enc("ACGTACGTAC") ^ (SW'(k) * 20'h01010);
      req_s1[k*SW +: SW] = s1v[k];
      req_s2[k*SW +: SW] = s2v[k];
    end

    // reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_grid_reset", 32'(grid_reset), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grid_s1", 32'(grid_s1), 32'd0);
    check("rst_resp_score", 32'(resp_score), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_timeout", 32'(resp_timeout), 32'd0);
    reset = 1'b0;

    // single job: delay 20, score 10
    req_valid = 4'b0001;
    wait_grant(g);
    check("t1_grant", 32'(g), 32'd0);
    check("t1_ready", 32'(req_ready), 32'b0001);
    check("t1_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = '0;
    check("t1_clr1_greset", 32'(grid_reset), 32'd1);
    check("t1_clr1_busy", 32'(busy), 32'd1);
    check("t1_clr1_ready", 32'(req_ready), 32'd0);
    check("t1_grid_s1", 32'(grid_s1), 32'(s1v[0]));
    check("t1_grid_s2", 32'(grid_s2), 32'(s2v[0]));
    @(negedge clk);
    check("t1_clr2_greset", 32'(grid_reset), 32'd1);
    @(negedge clk);
    check("t1_run_greset", 32'(grid_reset), 32'd0);
    wait_resp(n);
    check("t1_latency", 32'(n), 32'd21);
    check("t1_id", 32'(resp_id), 32'd0);
    check("t1_score", 32'(resp_score), 32'd10);
    check("t1_timeout", 32'(resp_timeout), 32'd0);
    @(negedge clk);
    check("t1_resp_drop", 32'(resp_valid), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // fairness from a fresh pointer
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("rst_ready_gate", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_delay = 3;
    for (int k = 0; k < 6; k++) begin
      model_score = SWIDTH'(100 + k);
      wait_grant(g);
      check("fair_grant", 32'(g), 32'(k % NREQ));
      @(negedge clk);
      if (k == 5) req_valid = '0;
      check("fair_grid_s1", 32'(grid_s1), 32'(s1v[k % NREQ]));
      wait_resp(n);
      check("fair_id", 32'(resp_id), 32'(k % NREQ));
      check("fair_score", 32'(resp_score), 32'(100 + k));
    end

    // backpressure with a negative score
    @(negedge clk);
    resp_ready = 1'b0;
    model_score = 16'hFFFD;
    req_valid = 4'b0100;
    wait_grant(g);
    check("bp_grant", 32'(g), 32'd2);
    @(negedge clk);
    req_valid = 4'b1111;
    wait_resp(n);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_id", 32'(resp_id), 32'd2);
      check("bp_score", 32'(resp_score), 32'hFFFD);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("bp_accept", 32'(resp_valid), 32'd0);

    // watchdog timeout
    model_en = 1'b0;
    req_valid = 4'b0010;
    wait_grant(g);
    check("to_grant", 32'(g), 32'd1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    wait_resp(n);
    check("to_latency", 32'(n), 32'(TMO));
    check("to_flag", 32'(resp_timeout), 32'd1);
    check("to_score", 32'(resp_score), 32'd0);
    check("to_id", 32'(resp_id), 32'd1);
    @(negedge clk);

    // normal job after timeout
    model_en = 1'b1;
    model_delay = 5;
    model_score = 16'd7;
    req_valid = 4'b0001;
    wait_grant(g);
    check("post_to_grant", 32'(g), 32'd0);
    @(negedge clk);
    req_valid = '0;
    wait_resp(n);
    check("post_to_score", 32'(resp_score), 32'd7);
    check("post_to_flag", 32'(resp_timeout), 32'd0);
    @(negedge clk);

    // stale valid into CLEAR and the first RUN cycle
    stale_force = 1'b1;
    model_delay = 6;
    model_score = 16'd55;
    req_valid = 4'b0010;
    wait_grant(g);
    check("st_grant", 32'(g), 32'd1);
    @(negedge clk);
    req_valid = '0;
    check("st_clr1", 32'(resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("st_run0", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("st_run1", 32'(resp_valid), 32'd0);
    stale_force = 1'b0;
    wait_resp(n);
    check("st_latency", 32'(n), 32'd6);
    check("st_score", 32'(resp_score), 32'd55);
    @(negedge clk);

    // reset during RUN
    model_en = 1'b0;
    req_valid = 4'b0100;
    wait_grant(g);
    check("mr_grant", 32'(g), 32'd2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 4'b1100;
    @(negedge clk);
    check("mr_grid_reset", 32'(grid_reset), 32'd1);
    check("mr_resp_valid", 32'(resp_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_grid_s1", 32'(grid_s1), 32'd0);
    check("mr_grid_s2", 32'(grid_s2), 32'd0);
    check("mr_ready", 32'(req_ready), 32'd0);
    check("mr_resp_id", 32'(resp_id), 32'd0);
    check("mr_resp_score", 32'(resp_score), 32'd0);
    reset = 1'b0;
    model_en = 1'b1;
    model_delay = 4;
    model_score = 16'd99;
    wait_grant(g);
    check("mr_regrant", 32'(g), 32'd2);
    @(negedge clk);
    req_valid = '0;
    wait_resp(n);
    check("mr_id", 32'(resp_id), 32'd2);
    check("mr_score", 32'(resp_score), 32'd99);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
